// File: rtl/modadd_ctrl.sv
// modadd_ctrl: modular add/subtract sequencer that drives a shared multi-cycle adder.
// Each operation uses two adder passes: a raw add/sub, then a correction by M.
module modadd_ctrl #(
  parameter int OP_W  = 1024,
  parameter int ADD_W = 1027
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             subtract,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic [OP_W-1:0]  in_m,
  output logic [OP_W-1:0]  result,
  output logic             done,
  output logic             busy,
  output logic             add_start,
  output logic             add_subtract,
  output logic [ADD_W-1:0] add_in_a,
  output logic [ADD_W-1:0] add_in_b,
  input  logic [ADD_W:0]   add_result,
  input  logic             add_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE1 = 3'd1,
    S_WAIT1  = 3'd2,
    S_ISSUE2 = 3'd3,
    S_WAIT2  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t            state_q;
  logic              sub_q;
  logic [OP_W-1:0]   m_q;
  logic [OP_W-1:0]   t_lo_q;
  logic              t_msb_q;
  logic [OP_W-1:0]   result_q;
  logic              done_q;
  logic              busy_q;
  logic              add_start_q;
  logic              add_sub_q;
  logic [ADD_W-1:0]  add_a_q;
  logic [ADD_W-1:0]  add_b_q;
  logic              accept_s;
  logic [OP_W-1:0]   result_sel_s;

  function automatic logic [ADD_W-1:0] zext(input logic [OP_W-1:0] v);
    return {{(ADD_W-OP_W){1'b0}}, v};
  endfunction

  assign accept_s = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Second-pass selection: add keeps t when t-M borrowed; sub adds M back only after a borrow.
  always_comb begin
    result_sel_s = t_lo_q;
    if (sub_q) begin
      if (t_msb_q) result_sel_s = add_result[OP_W-1:0];
      else         result_sel_s = t_lo_q;
    end else begin
      if (add_result[ADD_W]) result_sel_s = t_lo_q;
      else                   result_sel_s = add_result[OP_W-1:0];
    end
  end

  // Sequencer FSM with all outputs registered; add_start is a single-cycle pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      sub_q       <= 1'b0;
      m_q         <= '0;
      t_lo_q      <= '0;
      t_msb_q     <= 1'b0;
      result_q    <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      add_start_q <= 1'b0;
      add_sub_q   <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
    end else begin
      add_start_q <= 1'b0;
      done_q      <= 1'b0;
      if (accept_s) begin
        sub_q       <= subtract;
        m_q         <= in_m;
        add_a_q     <= zext(in_a);
        add_b_q     <= zext(in_b);
        add_sub_q   <= subtract;
        add_start_q <= 1'b1;
        busy_q      <= 1'b1;
        state_q     <= S_ISSUE1;
      end else begin
        case (state_q)
          S_IDLE:   state_q <= S_IDLE;
          S_ISSUE1: state_q <= S_WAIT1;
          S_WAIT1: begin
            if (add_done) begin
              t_lo_q      <= add_result[OP_W-1:0];
              t_msb_q     <= add_result[ADD_W];
              add_b_q     <= zext(m_q);
              add_start_q <= 1'b1;
              if (sub_q) begin
                add_a_q   <= zext(add_result[OP_W-1:0]);
                add_sub_q <= 1'b0;
              end else begin
                add_a_q   <= add_result[ADD_W-1:0];
                add_sub_q <= 1'b1;
              end
              state_q <= S_ISSUE2;
            end else begin
              state_q <= S_WAIT1;
            end
          end
          S_ISSUE2: state_q <= S_WAIT2;
          S_WAIT2: begin
            if (add_done) begin
              result_q <= result_sel_s;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= S_DONE;
            end else begin
              state_q <= S_WAIT2;
            end
          end
          S_DONE:   state_q <= S_IDLE;
          default: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign result       = result_q;
  assign done         = done_q;
  assign busy         = busy_q;
  assign add_start    = add_start_q;
  assign add_subtract = add_sub_q;
  assign add_in_a     = add_a_q;
  assign add_in_b     = add_b_q;

endmodule

// File: tb/tb_modadd_ctrl.sv
// Self-checking bench for modadd_ctrl: behavioural adder with selectable latency,
// arithmetic reference model, directed boundary cases and randomized operations.
module tb_modadd_ctrl;
  localparam int OP_W  = 1024;
  localparam int ADD_W = 1027;
  typedef logic [OP_W-1:0] op_t;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             start = 1'b0;
  logic             subtract = 1'b0;
  op_t              in_a = '0, in_b = '0, in_m = '0;
  op_t              result;
  logic             done, busy, add_start, add_subtract;
  logic [ADD_W-1:0] add_in_a, add_in_b;
  logic [ADD_W:0]   add_result = '0;
  logic             add_done;
  logic             mdl_done = 1'b0;
  logic             stray_done = 1'b0;

  assign add_done = mdl_done | stray_done;

  modadd_ctrl #(.OP_W(OP_W), .ADD_W(ADD_W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .subtract(subtract),
    .in_a(in_a), .in_b(in_b), .in_m(in_m), .result(result), .done(done),
    .busy(busy), .add_start(add_start), .add_subtract(add_subtract),
    .add_in_a(add_in_a), .add_in_b(add_in_b), .add_result(add_result),
    .add_done(add_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [ADD_W:0] obs, input logic [ADD_W:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (low 96 bits)", tag, obs[95:0], exp[95:0]);
  endtask

  // Behavioural adder: result appears lat cycles after the add_start pulse.
  int               lat = 3;
  int               cnt = 0;
  int               npulse = 0;
  logic             prev_start = 1'b0;
  logic [ADD_W:0]   pend;
  logic             l_sub;
  logic [ADD_W-1:0] l_a, l_b;
  logic             p_sub[4];
  logic [ADD_W-1:0] p_a[4], p_b[4];

  always @(posedge clk) begin
    #1;
    mdl_done = 1'b0;
    if (!resetn) begin
      cnt = 0;
      prev_start = 1'b0;
    end else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mdl_done = 1'b1;
          add_result = pend;
          chk("opnd_stable", {31'd0, (add_in_a == l_a) && (add_in_b == l_b) && (add_subtract == l_sub)}, 1);
        end
      end
      if (add_start) begin
        chk("add_start_gap", {31'd0, prev_start}, 0);
        if (npulse < 4) begin
          p_sub[npulse] = add_subtract;
          p_a[npulse]   = add_in_a;
          p_b[npulse]   = add_in_b;
        end
        npulse++;
        l_a = add_in_a; l_b = add_in_b; l_sub = add_subtract;
        pend = add_subtract ? ({1'b0, add_in_a} - {1'b0, add_in_b})
                            : ({1'b0, add_in_a} + {1'b0, add_in_b});
        cnt = lat;
      end
      prev_start = add_start;
    end
  end

  function automatic op_t ref_mod(input logic s, input op_t a, input op_t b, input op_t m);
    logic [OP_W:0] x;
    if (!s) begin
      x = {1'b0, a} + {1'b0, b};
      if (x >= {1'b0, m}) x = x - {1'b0, m};
    end else if (a >= b) begin
      x = {1'b0, a} - {1'b0, b};
    end else begin
      x = {1'b0, a} + {1'b0, m} - {1'b0, b};
    end
    return x[OP_W-1:0];
  endfunction

  function automatic op_t rnd_wide();
    op_t v;
    for (int i = 0; i < OP_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One operation from its start cycle; returns in the done cycle (#1 after the edge).
  task automatic run_op(input string tag, input logic s, input op_t a, input op_t b, input op_t m,
                        input int exp_cyc, input int poke_cyc, input logic hold_en, input op_t hold_val,
                        input logic stay_in_done);
    int   cyc;
    logic hold_ok;
    op_t  exp_r;
    exp_r = ref_mod(s, a, b, m);
    subtract = s; in_a = a; in_b = b; in_m = m; start = 1'b1; npulse = 0;
    cyc = 0; hold_ok = 1'b1;
    while (1) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (done || cyc >= 300) break;
      if (hold_en && (result !== hold_val)) hold_ok = 1'b0;
      if (cyc == 2) chk({tag, "_busy"}, {31'd0, busy}, 1);
      if (cyc == poke_cyc) begin
        start = 1'b1; in_a = ~a; in_b = ~b; subtract = ~s;
      end
    end
    chk({tag, "_done"}, {31'd0, done}, 1);
    if (exp_cyc > 0) chk({tag, "_lat"}, cyc, exp_cyc);
    chk({tag, "_res"}, result, exp_r);
    chk({tag, "_npulse"}, npulse, 2);
    chk({tag, "_p1"}, {p_sub[0], p_a[0], p_b[0]}, {s, ADD_W'(a), ADD_W'(b)} );
    chk({tag, "_p2"}, {p_sub[1], p_b[1]}, {~s, ADD_W'(m)});
    if (hold_en) chk({tag, "_hold"}, {31'd0, hold_ok}, 1);
    if (!stay_in_done) begin
      @(posedge clk); #1;
      chk({tag, "_pulse1"}, {31'd0, done}, 0);
    end
  endtask

  int   extra;
  op_t  mall, r1, ra, rb, rm;
  logic rs;

  initial begin
    #1;
    chk("rst_ctl", {28'd0, done, busy, add_start, add_subtract}, 0);
    chk("rst_res", result, 0);
    chk("rst_ain", {1'b0, add_in_a}, 0);
    chk("rst_bin", {1'b0, add_in_b}, 0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;

    lat = 3;
    run_op("add7_9",   1'b0, 7,  9,  13, 9, 0, 1'b0, '0, 1'b0);
    run_op("sub3_9",   1'b1, 3,  9,  13, 9, 0, 1'b0, '0, 1'b0);
    run_op("sub9_3",   1'b1, 9,  3,  13, 9, 0, 1'b0, '0, 1'b0);
    run_op("add5_8",   1'b0, 5,  8,  13, 9, 0, 1'b0, '0, 1'b0);
    run_op("add0_0",   1'b0, 0,  0,  13, 9, 0, 1'b0, '0, 1'b0);
    run_op("sub12_12", 1'b1, 12, 12, 13, 9, 0, 1'b0, '0, 1'b0);
    run_op("add12_12", 1'b0, 12, 12, 13, 9, 0, 1'b0, '0, 1'b0);
    chk("add12_12_val", result, 11);
    repeat (4) @(posedge clk); #1;
    chk("idle_hold", result, 11);

    lat = 1;
    mall = '1;
    run_op("full_add", 1'b0, mall - 1, mall - 1, mall, 5, 0, 1'b0, '0, 1'b0);
    chk("full_add_val", result, mall - 2);
    run_op("full_sub", 1'b1, 0, 1, mall, 5, 0, 1'b0, '0, 1'b0);
    chk("full_sub_val", result, mall - 1);

    // Start while busy is dropped.
    lat = 3;
    run_op("poke", 1'b0, 10, 6, 13, 9, 3, 1'b0, '0, 1'b0);
    extra = 0;
    repeat (15) begin @(posedge clk); #1; if (done) extra++; end
    chk("poke_nodone", extra, 0);

    // Back-to-back: second start in the done cycle.
    run_op("b2b_1", 1'b0, 11, 4, 13, 9, 0, 1'b0, '0, 1'b1);
    r1 = result;
    run_op("b2b_2", 1'b1, 2, 8, 13, 9, 0, 1'b1, r1, 1'b0);

    // Asynchronous reset in WAIT1.
    subtract = 1'b0; in_a = 7; in_b = 9; in_m = 13; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    chk("arst_ctl", {28'd0, done, busy, add_start, add_subtract}, 0);
    chk("arst_res", result, 0);
    chk("arst_ops", {1'b0, add_in_a | add_in_b}, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1; stray_done = 1'b1;
    @(posedge clk); #1; stray_done = 1'b0;
    extra = 0;
    repeat (12) begin @(posedge clk); #1; if (done || busy) extra++; end
    chk("stray_nodone", extra, 0);
    run_op("post_rst", 1'b0, 7, 9, 13, 9, 0, 1'b0, '0, 1'b0);

    // Randomized operations over random odd moduli and adder latencies.
    for (int k = 0; k < 16; k++) begin
      lat = $urandom_range(1, 4);
      rm = rnd_wide() >> $urandom_range(0, OP_W - 2);
      rm[0] = 1'b1;
      ra = rnd_wide() % rm;
      rb = rnd_wide() % rm;
      rs = $urandom_range(0, 1) == 1;
      if (k % 5 == 1) rb = ra;
      if (k % 5 == 2 && ra != 0) rb = rm - ra;
      run_op("rand", rs, ra, rb, rm, 3 + 2 * lat, 0, 1'b0, '0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
